// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multicycle MIPS main control unit.
// The mux select encodings are also used by the datapath mux instances.
package mc_pkg;

    localparam int OPW = 6;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWR  = 4'd5,
        S_MEMWB  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_e;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    // 2'b11 is reserved on the PC mux and is never produced.
    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_e;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
        pc_src_e    pc_source;
        logic       illegal_op;
    } ctrl_word_t;

    function automatic logic op_is_legal(input logic [OPW-1:0] op);
        return (op == OP_LW)  || (op == OP_SW)  || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_ADDI)  ||
               (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control-unit bus: IR opcode and status flags in, per-cycle control word out.
// master = control FSM, slave = datapath.
interface mc_control_fsm_if;
    import mc_pkg::*;

    logic [OPW-1:0] opcode;
    logic           zero;
    logic           mem_ready;
    logic           pc_en;
    logic           iord;
    logic           mem_read;
    logic           mem_write;
    logic           ir_write;
    logic           mem_to_reg;
    logic           reg_dst;
    logic           reg_write;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     alu_op;
    logic [1:0]     pc_source;
    logic           illegal_op;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal_op
    );

endinterface

// File: rtl/mc_control_fsm_decode.sv
// Combinational control-word decode: Moore in state, plus zero/mem_ready
// for pc_en and ir_write, plus the DECODE-cycle illegal-opcode flag.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  state_e     i_state,
    input  logic       i_is_bne,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    input  logic       i_op_illegal,
    output ctrl_word_t o_ctrl
);

    always_comb begin
        // NOTE: every field gets a default first, so no path can infer a latch.
        o_ctrl = '0;
        unique case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_en     = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b  = SRCB_IMM_SH2;
                o_ctrl.illegal_op = i_op_illegal;
            end
            S_MEMADR, S_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                o_ctrl.iord     = 1'b1;
                o_ctrl.mem_read = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.iord      = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_SUB;
                o_ctrl.pc_source = PCSRC_ALUOUT;
                o_ctrl.pc_en     = i_zero ^ i_is_bne;
            end
            S_ADDIWB: o_ctrl.reg_write = 1'b1;
            S_JUMP: begin
                o_ctrl.pc_source = PCSRC_JUMP;
                o_ctrl.pc_en     = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM: state register, branch-flavour latch and
// next-state logic; the control word comes from mc_ctrl_decode.
module mc_control_fsm
    import mc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    mc_control_fsm_if.master  bus
);

    state_e     r_state;
    state_e     w_next_state;
    logic       r_is_bne;
    logic       w_op_illegal;
    ctrl_word_t w_ctrl;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Only the flavour is kept, so the IR may change once DECODE is over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_bne <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_is_bne <= (bus.opcode == OP_BNE);
        end
    end

    assign w_op_illegal = !op_is_legal(bus.opcode);

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_RESET:  w_next_state = S_FETCH;
            S_FETCH:  if (bus.mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                unique case (bus.opcode)
                    OP_LW, OP_SW:   w_next_state = S_MEMADR;
                    OP_RTYPE:       w_next_state = S_EXEC;
                    OP_BEQ, OP_BNE: w_next_state = S_BRANCH;
                    OP_ADDI:        w_next_state = S_ADDIEX;
                    OP_J:           w_next_state = S_JUMP;
                    default:        w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: w_next_state = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) w_next_state = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) w_next_state = S_FETCH;
            S_EXEC:   w_next_state = S_ALUWB;
            S_ADDIEX: w_next_state = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
                      w_next_state = S_FETCH;
            default:  w_next_state = S_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .i_state      (r_state),
        .i_is_bne     (r_is_bne),
        .i_zero       (bus.zero),
        .i_mem_ready  (bus.mem_ready),
        .i_op_illegal (w_op_illegal),
        .o_ctrl       (w_ctrl)
    );

    assign bus.pc_en      = w_ctrl.pc_en;
    assign bus.iord       = w_ctrl.iord;
    assign bus.mem_read   = w_ctrl.mem_read;
    assign bus.mem_write  = w_ctrl.mem_write;
    assign bus.ir_write   = w_ctrl.ir_write;
    assign bus.mem_to_reg = w_ctrl.mem_to_reg;
    assign bus.reg_dst    = w_ctrl.reg_dst;
    assign bus.reg_write  = w_ctrl.reg_write;
    assign bus.alu_src_a  = w_ctrl.alu_src_a;
    assign bus.alu_src_b  = w_ctrl.alu_src_b;
    assign bus.alu_op     = w_ctrl.alu_op;
    assign bus.pc_source  = w_ctrl.pc_source;
    assign bus.illegal_op = w_ctrl.illegal_op;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Table-driven bench for mc_control_fsm: one row per clock cycle holding the
// inputs for that cycle and the hand-written control word expected in it.
module tb_mc_control_fsm;

    // Word order: {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg,
    //              reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op}
    localparam logic [15:0] E_ZERO    = 16'h0000;
    localparam logic [15:0] E_FETCH   = {9'b1_0_1_0_1_0_0_0_0, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_FWAIT   = {9'b0_0_1_0_0_0_0_0_0, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_DECODE  = {9'b0_0_0_0_0_0_0_0_0, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_DEC_ILL = {9'b0_0_0_0_0_0_0_0_0, 2'b11, 2'b00, 2'b00, 1'b1};
    localparam logic [15:0] E_MEMADR  = {9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_MEMRD   = {9'b0_1_1_0_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_MEMWR   = {9'b0_1_0_1_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_MEMWB   = {9'b0_0_0_0_0_1_0_1_0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_EXEC    = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [15:0] E_ALUWB   = {9'b0_0_0_0_0_0_1_1_0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_BR_TK   = {9'b1_0_0_0_0_0_0_0_1, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [15:0] E_BR_NT   = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [15:0] E_ADDIEX  = {9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_ADDIWB  = {9'b0_0_0_0_0_0_0_1_0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_JUMP    = {9'b1_0_0_0_0_0_0_0_0, 2'b00, 2'b00, 2'b10, 1'b0};

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RTY  = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [15:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    mc_control_fsm_if bus ();

    mc_control_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] actual_word();
        return {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [5:0] op, input logic zero,
                       input logic rdy, input logic [15:0] exp);
        vec_t v;
        v.name = name;
        v.op   = op;
        v.zero = zero;
        v.rdy  = rdy;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    // Entered just after a rising edge; checks at the falling edge and
    // returns just after the next rising edge.
    task automatic run_row(input vec_t v);
        bus.opcode    = v.op;
        bus.zero      = v.zero;
        bus.mem_ready = v.rdy;
        @(negedge clk);
        check(v.name, actual_word(), v.exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        n_tests = 0;
        n_fail  = 0;

        // lw, no stalls: 5 cycles, writeback only in the last
        add("lw_fetch",   LW, 1'b0, 1'b1, E_FETCH);
        add("lw_decode",  LW, 1'b0, 1'b1, E_DECODE);
        add("lw_memadr",  LW, 1'b0, 1'b1, E_MEMADR);
        add("lw_memrd",   LW, 1'b0, 1'b1, E_MEMRD);
        add("lw_memwb",   LW, 1'b0, 1'b1, E_MEMWB);
        // sw, two wait cycles in MEMWR: 6 cycles
        add("sw_fetch",   SW, 1'b0, 1'b1, E_FETCH);
        add("sw_decode",  SW, 1'b0, 1'b1, E_DECODE);
        add("sw_memadr",  SW, 1'b0, 1'b1, E_MEMADR);
        add("sw_memwr0",  SW, 1'b0, 1'b0, E_MEMWR);
        add("sw_memwr1",  SW, 1'b0, 1'b0, E_MEMWR);
        add("sw_memwr2",  SW, 1'b0, 1'b1, E_MEMWR);
        // R-type
        add("r_fetch",    RTY, 1'b1, 1'b1, E_FETCH);
        add("r_decode",   RTY, 1'b1, 1'b1, E_DECODE);
        add("r_exec",     RTY, 1'b1, 1'b1, E_EXEC);
        add("r_aluwb",    RTY, 1'b1, 1'b1, E_ALUWB);
        // addi
        add("addi_fetch", ADDI, 1'b0, 1'b1, E_FETCH);
        add("addi_dec",   ADDI, 1'b0, 1'b1, E_DECODE);
        add("addi_ex",    ADDI, 1'b0, 1'b1, E_ADDIEX);
        add("addi_wb",    ADDI, 1'b0, 1'b1, E_ADDIWB);
        // beq taken
        add("beq1_fetch", BEQ, 1'b1, 1'b1, E_FETCH);
        add("beq1_dec",   BEQ, 1'b1, 1'b1, E_DECODE);
        add("beq1_br",    BEQ, 1'b1, 1'b1, E_BR_TK);
        // bne with zero=1 not taken; opcode swapped to beq in BRANCH is ignored
        add("bne1_fetch", BNE, 1'b1, 1'b1, E_FETCH);
        add("bne1_dec",   BNE, 1'b1, 1'b1, E_DECODE);
        add("bne1_br",    BEQ, 1'b1, 1'b1, E_BR_NT);
        // beq not taken, bne taken
        add("beq0_fetch", BEQ, 1'b0, 1'b1, E_FETCH);
        add("beq0_dec",   BEQ, 1'b0, 1'b1, E_DECODE);
        add("beq0_br",    BEQ, 1'b0, 1'b1, E_BR_NT);
        add("bne0_fetch", BNE, 1'b0, 1'b1, E_FETCH);
        add("bne0_dec",   BNE, 1'b0, 1'b1, E_DECODE);
        add("bne0_br",    BNE, 1'b0, 1'b1, E_BR_TK);
        // jump
        add("j_fetch",    JMP, 1'b0, 1'b1, E_FETCH);
        add("j_dec",      JMP, 1'b0, 1'b1, E_DECODE);
        add("j_jump",     JMP, 1'b0, 1'b1, E_JUMP);
        // illegal opcode: one-cycle pulse, back to FETCH
        add("ill_fetch",  BAD, 1'b0, 1'b1, E_FETCH);
        add("ill_dec",    BAD, 1'b0, 1'b1, E_DEC_ILL);
        // fetch stall, then lw with one MEMRD stall
        add("lws_fwait",  LW, 1'b0, 1'b0, E_FWAIT);
        add("lws_fetch",  LW, 1'b0, 1'b1, E_FETCH);
        add("lws_dec",    LW, 1'b0, 1'b1, E_DECODE);
        add("lws_memadr", LW, 1'b0, 1'b1, E_MEMADR);
        add("lws_rdwait", LW, 1'b0, 1'b0, E_MEMRD);
        add("lws_memrd",  LW, 1'b0, 1'b1, E_MEMRD);
        add("lws_memwb",  LW, 1'b0, 1'b1, E_MEMWB);

        rst_n         = 1'b0;
        bus.opcode    = BAD;
        bus.zero      = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", actual_word(), E_ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_pre_edge", actual_word(), E_ZERO);
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_row(vecs[i]);

        // sw interrupted by async reset while stalled in MEMWR
        v.zero = 1'b0;
        v.op   = SW;
        v.rdy  = 1'b1;
        v.name = "rst_sw_fetch";  v.exp = E_FETCH;  run_row(v);
        v.name = "rst_sw_decode"; v.exp = E_DECODE; run_row(v);
        v.name = "rst_sw_memadr"; v.exp = E_MEMADR; run_row(v);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("rst_sw_memwr_before", actual_word(), E_MEMWR);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", actual_word(), E_ZERO);
        check("rst_async_state", 16'(dut.r_state), 16'd0);
        @(posedge clk);
        #1;
        check("rst_held_outputs", actual_word(), E_ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_recover_fetch", actual_word(), E_FETCH);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS main control unit; produces every per-cycle control word, including the 2-bit select fields that drive the datapath's 4:1 operand/PC multiplexers.
- Sequences each instruction through fetch, decode, execute, memory and writeback states from the IR opcode.
- Stalls on a memory-ready handshake and gates PC update with the ALU zero flag for branches.

Parameters:
- OPW, 6, opcode field width (fixed by ISA; exposed for the package only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory handshake; 1 = access completes this cycle.
- pc_en  out  1  PC load enable.
- iord  out  1  memory address mux: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load enable.
- mem_to_reg  out  1  register write data mux: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  destination register mux: 0 = rt, 1 = rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A mux: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B mux: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = use funct.
- pc_source  out  2  PC source mux: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = reserved (never driven).
- illegal_op  out  1  one-cycle pulse on an unknown opcode.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- While rst_n = 0: state = RESET and all outputs are 0.
- First rising edge after rst_n deasserts: RESET -> FETCH.
- Outputs are a Moore decode of the state, except pc_en, which also uses zero and mem_ready.
- Any output not listed for a state is 0.
- FETCH:
  - iord = 0, mem_read = 1, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write and pc_en equal mem_ready.
  - Stays in FETCH while mem_ready = 0; moves to DECODE when mem_ready = 1.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) and 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXEC.
  - 000100 (beq) and 000101 (bne) -> BRANCH.
  - 001000 (addi) -> ADDIEX.
  - 000010 (j) -> JUMP.
  - Any other opcode -> FETCH, with illegal_op = 1 for this DECODE cycle.
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: iord = 1, mem_read = 1. Stays while mem_ready = 0; otherwise -> MEMWB.
- MEMWR: iord = 1, mem_write = 1. Stays while mem_ready = 0; otherwise -> FETCH.
- MEMWB: reg_dst = 0, mem_to_reg = 1, reg_write = 1. -> FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. -> ALUWB.
- ALUWB: reg_dst = 1, mem_to_reg = 0, reg_write = 1. -> FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01.
  - pc_en = zero for beq, ~zero for bne.
  - The branch flavour is latched at DECODE into a 1-bit register, so opcode changes after DECODE are ignored.
  - -> FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. -> ADDIWB.
- ADDIWB: reg_dst = 0, mem_to_reg = 0, reg_write = 1. -> FETCH.
- JUMP: pc_source = 10, pc_en = 1. -> FETCH.
- Boundary conditions:
  - mem_write and mem_read are never both 1.
  - reg_write and pc_en are never both 1, except none: no state asserts both.
  - Reset asserted mid-instruction (including during a stalled MEMWR) drops all outputs in the same cycle, with no clock edge required.
- Latency without stalls, in cycles: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3. Each mem_ready = 0 cycle adds 1.

Decomposition:
- Package mc_pkg holds:
  - the state enum (RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWR, MEMWB, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP), 4-bit binary encoding;
  - opcode constants;
  - alu_src_b, alu_op and pc_source encodings, shared with the datapath mux instances.
- One natural sub-module: mc_ctrl_decode, a purely combinational map from state, latched branch flavour, zero and mem_ready to the control word.
- The state register and next-state logic stay in mc_control_fsm.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles -> all outputs 0. Release -> FETCH next edge, with mem_read = 1 and alu_src_b = 01.
- lw with mem_ready tied 1, opcode 100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB (5 cycles). reg_write = 1 and mem_to_reg = 1 only in cycle 5.
- sw, opcode 101011, with mem_ready = 0 for 2 cycles in MEMWR -> mem_write = 1 for 3 cycles, iord = 1, then FETCH. Total 6 cycles.
- beq with zero = 1 -> pc_en = 1 and pc_source = 01 in BRANCH. bne with zero = 1 -> pc_en = 0. Both take 3 cycles.
- Opcode 111111 -> illegal_op = 1 for exactly the DECODE cycle, then FETCH. No reg_write or mem_write is ever asserted.
- Assert rst_n = 0 asynchronously mid-MEMWR -> mem_write drops to 0 before the next clk edge; state = RESET.
